// File: rtl/melody_seq_ctrl_if.sv
// Handshake/bus bundle between the melody sequencer and its environment
// (control pulses, live keys, note ROM port and tone outputs).
interface melody_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NOTE_W = 5,
    parameter int unsigned DUR_W  = 3
);
    logic                    tick_in;
    logic                    start_in;
    logic                    stop_in;
    logic                    key_valid_in;
    logic [NOTE_W-1:0]       key_note_in;
    logic [ADDR_W-1:0]       rom_addr_out;
    logic [NOTE_W+DUR_W-1:0] rom_data_in;
    logic [NOTE_W-1:0]       note_out;
    logic                    note_valid_out;
    logic                    busy_out;
    logic                    done_out;

    modport slave (
        input  tick_in, start_in, stop_in, key_valid_in, key_note_in, rom_data_in,
        output rom_addr_out, note_out, note_valid_out, busy_out, done_out
    );

    modport master (
        output tick_in, start_in, stop_in, key_valid_in, key_note_in, rom_data_in,
        input  rom_addr_out, note_out, note_valid_out, busy_out, done_out
    );
endinterface

// File: rtl/melody_seq_ctrl.sv
// Beat-driven melody sequencer reading {note, dur} words from a synchronous ROM, with
// live-key priority on the note output. Define MELODY_LOOP_EN to repeat the song.
module melody_seq_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NOTE_W = 5,
    parameter int unsigned DUR_W  = 3
) (
    input logic               clk_in,
    input logic               rst_n_in,
    melody_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NOTE_W-1:0]   seq_note_q, seq_note_d;
    logic [DUR_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                note_valid_q, note_valid_d;
    logic                busy, done;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                last_addr;

    assign rom_note  = bus.rom_data_in[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur   = bus.rom_data_in[DUR_W-1:0];
    assign last_addr = (addr_q == {ADDR_W{1'b1}});

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            seq_note_q   <= '0;
            beat_cnt_q   <= '0;
            note_q       <= '0;
            note_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            seq_note_q   <= seq_note_d;
            beat_cnt_q   <= beat_cnt_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        seq_note_d = seq_note_q;
        beat_cnt_d = beat_cnt_q;
        if (bus.stop_in) begin
            // stop wins over any simultaneous start or tick
            state_d    = StIdle;
            addr_d     = '0;
            seq_note_d = '0;
            beat_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        addr_d  = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: state_d = StLoad;
                StLoad: begin
                    if (rom_dur == '0) begin
                        state_d = StDone;
                    end else begin
                        seq_note_d = rom_note;
                        beat_cnt_d = rom_dur;
                        state_d    = StPlay;
                    end
                end
                StPlay: begin
                    if (bus.tick_in) begin
                        if (beat_cnt_q > DUR_W'(1)) begin
                            beat_cnt_d = beat_cnt_q - DUR_W'(1);
                        end else if (last_addr) begin
                            state_d = StDone;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                    end
                end
                StDone: begin
`ifdef MELODY_LOOP_EN
                    addr_d  = '0;
                    state_d = StFetch;
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        if (bus.key_valid_in) begin
            note_d       = bus.key_note_in;
            note_valid_d = |bus.key_note_in;
        end else if (state_q == StPlay) begin
            note_d       = seq_note_q;
            note_valid_d = |seq_note_q;
        end else begin
            note_d       = '0;
            note_valid_d = 1'b0;
        end
    end

    assign bus.rom_addr_out   = addr_q;
    assign bus.note_out       = note_q;
    assign bus.note_valid_out = note_valid_q;
    assign bus.busy_out       = busy;
    assign bus.done_out       = done;
endmodule

// File: tb/tb_melody_seq_ctrl.sv
// Randomized self-checking bench for melody_seq_ctrl against a song-level reference model.
module tb_melody_seq_ctrl;
    localparam int AW = 5;
    localparam int NW = 5;
    localparam int DW = 3;
    localparam int SONG_LEN = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    melody_seq_ctrl_if #(.ADDR_W(AW), .NOTE_W(NW), .DUR_W(DW)) ifc ();

    melody_seq_ctrl #(.ADDR_W(AW), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifc)
    );

    logic [NW+DW-1:0] rom_mem [SONG_LEN];
    always @(posedge clk) ifc.rom_data_in <= rom_mem[ifc.rom_addr_out];

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: song position, pending fetch gap and remaining beats of the current note
    bit m_busy, m_done;
    int m_gap, m_beats, m_idx, m_note;
    int e_note;
    bit e_valid;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_gap = 0; m_beats = 0; m_idx = 0; m_note = 0;
        e_note = 0; e_valid = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit tk, input bit kv, input int kn);
        bit playing;
        int dur, nt;
        playing = m_busy && !m_done && (m_gap == 0) && (m_beats > 0);
        if (kv) begin
            e_note = kn; e_valid = (kn != 0);
        end else if (playing) begin
            e_note = m_note; e_valid = (m_note != 0);
        end else begin
            e_note = 0; e_valid = 0;
        end
        dur = int'(rom_mem[m_idx] % (1 << DW));
        nt  = int'(rom_mem[m_idx] >> DW);
        if (sp) begin
            m_busy = 0; m_done = 0; m_gap = 0; m_beats = 0; m_idx = 0; m_note = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_idx = 0; m_gap = 2;
            end
        end else if (m_done) begin
            m_done = 0;
`ifdef MELODY_LOOP_EN
            m_idx = 0; m_gap = 2;
`else
            m_busy = 0;
`endif
        end else if (m_gap == 2) begin
            m_gap = 1;
        end else if (m_gap == 1) begin
            m_gap = 0;
            if (dur == 0) m_done = 1;
            else begin
                m_note = nt; m_beats = dur;
            end
        end else if (tk) begin
            if (m_beats > 1) m_beats--;
            else begin
                m_beats = 0;
                if (m_idx == SONG_LEN - 1) m_done = 1;
                else begin
                    m_idx++; m_gap = 2;
                end
            end
        end
    endtask

    task automatic cyc(input bit st, input bit sp, input bit tk, input bit kv, input int kn);
        @(negedge clk);
        ifc.start_in = st; ifc.stop_in = sp; ifc.tick_in = tk;
        ifc.key_valid_in = kv; ifc.key_note_in = NW'(kn);
        @(posedge clk);
        model_step(st, sp, tk, kv, kn);
        #1;
        check_eq("note_out", 32'(ifc.note_out), 32'(e_note));
        check_eq("note_valid_out", 32'(ifc.note_valid_out), 32'(e_valid));
        check_eq("rom_addr_out", 32'(ifc.rom_addr_out), 32'(m_idx));
        check_eq("busy_out", 32'(ifc.busy_out), 32'(m_busy));
        check_eq("done_out", 32'(ifc.done_out), 32'(m_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_note"}, 32'(ifc.note_out), 0);
        check_eq({tag, "_valid"}, 32'(ifc.note_valid_out), 0);
        check_eq({tag, "_addr"}, 32'(ifc.rom_addr_out), 0);
        check_eq({tag, "_busy"}, 32'(ifc.busy_out), 0);
        check_eq({tag, "_done"}, 32'(ifc.done_out), 0);
    endtask

    task automatic load_plan_rom();
        for (int i = 0; i < SONG_LEN; i++) rom_mem[i] = '0;
        rom_mem[0] = {5'd5, 3'd2};
        rom_mem[1] = {5'd9, 3'd1};
        rom_mem[2] = {5'd17, 3'd0};
    endtask

    initial begin
        ifc.start_in = 0; ifc.stop_in = 0; ifc.tick_in = 0;
        ifc.key_valid_in = 0; ifc.key_note_in = '0;
        load_plan_rom();
        model_reset();
        #2 rst_n = 0;
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1;

        // Plan song with a key override during note 5 and an ignored second start
        for (int i = 0; i < 60; i++)
            cyc(i == 2 || i == 7, 0, (i % 6) == 5, i >= 9 && i <= 18, 12);

        // Stop coincident with terminal tick
        for (int i = 0; i < 14; i++)
            cyc(i == 2, i == 8, i == 5 || i == 8, 0, 0);

        // Start and stop together in idle
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

        // Full-length song, no end marker, includes a silent 3-beat note
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < SONG_LEN; i++)
            rom_mem[i] = {NW'($urandom_range(0, 31)), DW'($urandom_range(1, 7))};
        rom_mem[4] = {5'd0, 3'd3};
        for (int i = 0; i < 1400; i++)
            cyc(i == 1, 0, $urandom_range(0, 3) == 0, 0, 0);

        // Fully random controls over a random song with occasional end markers
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < SONG_LEN; i++)
            rom_mem[i] = {NW'($urandom_range(0, 31)),
                          ($urandom_range(0, 9) == 0) ? 3'd0 : DW'($urandom_range(1, 7))};
        begin
            bit kv = 0;
            int kn = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 24) == 0) begin
                    kv = !kv;
                    kn = $urandom_range(0, 31);
                end
                cyc($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                    $urandom_range(0, 4) == 0, kv, kn);
            end
        end

        // Asynchronous reset mid-song
        cyc(0, 1, 0, 0, 0);
        load_plan_rom();
        rom_mem[2] = {5'd3, 3'd7};
        for (int i = 0; i < 12; i++) cyc(i == 0, 0, i == 6, 0, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/melody_seq_ctrl.md
# melody_seq_ctrl

Beat-driven melody sequencer and buzzer-source arbiter for the piano shield. It steps through a song held in an external synchronous note ROM, one note per ROM word. Each note is held for a number of beats counted on the 4 Hz beat tick from the shared tick generator. Live piano keys always take priority for the note output over the playing song; the tone generator downstream converts `note_out` to a divider value.

## Interface
Parameters:
- `ADDR_W`, 5: ROM address width; song length is at most 2^ADDR_W words.
- `NOTE_W`, 5: note code width; code 0 = rest.
- `DUR_W`, 3: duration field width in beats; duration 0 = end-of-song marker.

Ports:
- `clk_in`, input, 1: system clock. One clock domain.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `tick_in`, input, 1: one-cycle beat pulse (4 Hz).
- `start_in`, input, 1: one-cycle start request.
- `stop_in`, input, 1: one-cycle stop request.
- `key_valid_in`, input, 1: a piano key is held.
- `key_note_in`, input, NOTE_W: note code of the held key.
- `rom_addr_out`, output, ADDR_W: registered ROM address.
- `rom_data_in`, input, NOTE_W+DUR_W: ROM word `{note, dur}`. The ROM is synchronous with 1-cycle latency.
- `note_out`, output, NOTE_W: registered note code to the tone generator.
- `note_valid_out`, output, 1: registered; tone enabled.
- `busy_out`, output, 1: song playback active.
- `done_out`, output, 1: one-cycle pulse at song end.

## Operation
State machine states: IDLE, FETCH, LOAD, PLAY, DONE. Reset state is IDLE.

- **IDLE:** `busy_out`=0.
  - `start_in` → `addr`=0, go to FETCH.
- **FETCH:** `rom_addr_out`=`addr` is presented; the ROM samples it at the end of this cycle.
  - Always go to LOAD.
- **LOAD:** `rom_data_in` is valid.
  - `dur`==0 → go to DONE.
  - Otherwise latch `note`, set `beat_cnt`=`dur`, go to PLAY.
- **PLAY:** the sequencer note is the latched note.
  - On `tick_in` with `beat_cnt`>1: decrement `beat_cnt`.
  - On `tick_in` with `beat_cnt`==1, not at the last address: `addr`+1, go to FETCH.
  - On `tick_in` with `beat_cnt`==1, at the last address (`addr`==2^ADDR_W-1): go to DONE.
- **DONE:** `done_out`=1 for this single cycle, then go to IDLE (see Configuration for the loop variant).

Controls and boundary rules:
- `stop_in` in any state → IDLE at the next edge, with `addr`=0 and the sequencer note cleared. `stop_in` has priority over a simultaneous `start_in` and over a simultaneous tick.
- `start_in` outside IDLE is ignored.
- `tick_in` in FETCH, LOAD or DONE is ignored. The beat count of a note begins on entry to PLAY. Ticks are millions of cycles apart, so no beat is lost in practice.
- `busy_out`=1 in FETCH, LOAD, PLAY and DONE.

Output arbitration, registered every cycle in every state:
- `key_valid_in`=1 → `note_out`=`key_note_in`, `note_valid_out`=(`key_note_in`≠0).
- Otherwise, in PLAY → `note_out`=sequencer note, `note_valid_out`=(note≠0).
- Otherwise → `note_out`=0, `note_valid_out`=0.
- The sequencer keeps its beat count while a key overrides the output, so the song tempo is preserved.

## Timing
- Reset values: `rom_addr_out`=0, `note_out`=0, `note_valid_out`=0, `busy_out`=0, `done_out`=0, `beat_cnt`=0.
- Start latency: `start_in` sampled at edge k → FETCH after edge k → LOAD after edge k+1 → PLAY after k+2. First note appears on `note_out` after edge k+3, because of the output register.
- Note advance: the terminal tick sampled at edge t → next note on `note_out` after edge t+3.
- Key override: `key_valid_in` change at edge k → visible on `note_out`/`note_valid_out` after edge k+1.
- A note of `dur`=d lasts d ticks plus a 3-cycle fetch gap.
- Reset asserted mid-song: all outputs go to reset values immediately, asynchronously.

## Configuration
- `MELODY_LOOP_EN` defined: DONE still pulses `done_out`, then goes to FETCH with `addr`=0, so `busy_out` stays 1. Playback repeats until `stop_in`.
- `MELODY_LOOP_EN` undefined: DONE goes to IDLE as described above.

## Test plan
- Reset, then ROM = {note 5, dur 2}, {note 9, dur 1}, {x, dur 0}. Pulse start.
  - `note_out`=5 three cycles after start, held for 2 ticks.
  - `note_out`=9 for 1 tick.
  - `done_out` pulses once, `busy_out`=0 afterwards, `note_out`=0.
- During note 5, hold `key_valid_in`=1 with `key_note_in`=12 for 10 cycles.
  - `note_out`=12 one cycle later, then back to 5.
  - Note 9 still starts at the same tick as without the key.
- `stop_in` asserted together with a terminal tick in PLAY → next state IDLE, `rom_addr_out`=0, `done_out` stays 0.
- `start_in` and `stop_in` asserted in the same cycle in IDLE → stays IDLE. A second `start_in` while in PLAY is ignored.
- Full 32-word ROM with no 0-duration word.
  - `addr` 31 terminal tick → DONE.
  - With `MELODY_LOOP_EN`: `rom_addr_out` returns to 0, `busy_out` stays 1.
- Note code 0 with `dur` 3 → `note_valid_out`=0 for 3 ticks, `busy_out`=1.
